// File: rtl/gpu_frame_loader.sv
// Once per frame, takes the CPU data-memory read port and streams the
// rectangle table into the GPU, one word per clock.
module gpu_frame_loader #(
  parameter int                    RECT_COUNT     = 64,
  parameter int                    WORDS_PER_RECT = 6,
  parameter int                    ADDR_WIDTH     = 13,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
  input  logic                  pixel_clk,
  input  logic                  reset,
  input  logic                  vblank,
  input  logic                  cpu_commit,
  input  logic [15:0]           mem_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  output logic                  cpu_stall,
  output logic                  gpu_idle,
  output logic                  gpu_we,
  output logic [15:0]           gpu_din,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  output logic [7:0]            frame_count,
  output logic [2:0]            dbg_state
);

  localparam int N     = RECT_COUNT * WORDS_PER_RECT;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GRANT  = 3'd1,
    S_START  = 3'd2,
    S_STREAM = 3'd3,
    S_FINISH = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;
  logic [7:0]       frame_count_q, frame_count_d;

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      pending_q     <= 1'b0;
      overrun_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pending_d     = pending_q | cpu_commit;
    overrun_d     = overrun_q;
    frame_count_d = frame_count_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (vblank && pending_q) begin
          state_d   = S_GRANT;
          // A commit landing on the grant edge belongs to the next frame.
          pending_d = cpu_commit;
        end
      end
      S_GRANT:  state_d = S_START;
      S_START: begin
        cnt_d   = CNT_W'(1);
        state_d = (N == 1) ? S_FINISH : S_STREAM;
      end
      S_STREAM: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) state_d = S_FINISH;
      end
      S_FINISH: begin
        frame_count_d = frame_count_q + 8'd1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // The copy is never cut short: the GPU would be stranded mid-COPY.
    if (state_q != S_IDLE && !vblank) overrun_d = 1'b1;
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    cpu_stall   = (state_q != S_IDLE);
    gpu_idle    = (state_q == S_GRANT);
    gpu_we      = (state_q == S_START);
    mem_rd      = (state_q == S_START) || (state_q == S_STREAM);
    done        = (state_q == S_FINISH);
    overrun     = overrun_q;
    frame_count = frame_count_q;
    dbg_state   = state_q;
    mem_addr    = '0;
    if (state_q == S_START)  mem_addr = BASE_ADDR;
    if (state_q == S_STREAM) mem_addr = BASE_ADDR + ADDR_WIDTH'(cnt_q);
  end

  assign gpu_din = mem_rdata;

endmodule

// File: tb/tb_gpu_frame_loader.sv
// Scoreboarded bench for gpu_frame_loader: a phase-count reference model
// predicts every cycle's outputs; a monitor compares them at each negedge.
module tb_gpu_frame_loader;

  localparam int             N    = 384;
  localparam int             AW   = 13;
  localparam logic [AW-1:0]  BASE = '0;
  localparam int             W    = 45;

  logic           pixel_clk  = 1'b0;
  logic           reset      = 1'b1;
  logic           vblank     = 1'b0;
  logic           cpu_commit = 1'b0;
  logic [15:0]    mem_rdata  = 16'h0;
  logic [AW-1:0]  mem_addr;
  logic           mem_rd, cpu_stall, gpu_idle, gpu_we, busy, done, overrun;
  logic [15:0]    gpu_din;
  logic [7:0]     frame_count;
  logic [2:0]     dbg_state;

  logic [15:0]    mem [0:8191];

  gpu_frame_loader dut (
    .pixel_clk   (pixel_clk),
    .reset       (reset),
    .vblank      (vblank),
    .cpu_commit  (cpu_commit),
    .mem_rdata   (mem_rdata),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .cpu_stall   (cpu_stall),
    .gpu_idle    (gpu_idle),
    .gpu_we      (gpu_we),
    .gpu_din     (gpu_din),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun),
    .frame_count (frame_count),
    .dbg_state   (dbg_state)
  );

  // clock / memory
  always #5 pixel_clk = ~pixel_clk;

  always @(posedge pixel_clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  // reference model state: m_ph = cycles since GRANT, -1 when idle
  int             m_ph = -1;
  bit             m_pend, m_ovr;
  logic [7:0]     m_fc;
  logic [W-1:0]   exp_q[$];
  int             checks = 0, errors = 0;
  logic [15:0]    cap [0:N-1];
  int             cap_n = N;
  bit             cap_on;

  function automatic logic [W-1:0] model_exp();
    logic [AW-1:0] a;
    logic [15:0]   d;
    bit            rd, dv;
    rd = (m_ph >= 1) && (m_ph <= N);
    dv = (m_ph >= 2) && (m_ph <= N + 1);
    a  = rd ? BASE + AW'(m_ph - 1) : '0;
    d  = dv ? mem[BASE + AW'(m_ph - 2)] : 16'h0;
    return {m_ph >= 0, m_ph >= 0, m_ph == 0, m_ph == 1, rd, m_ph == N + 1,
            m_ovr, m_fc, a, dv, d};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 25) $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, req);
    end
  endtask

  task automatic model_loop();
    bit enter;
    forever begin
      @(posedge pixel_clk or posedge reset);
      if (reset) begin
        m_ph = -1; m_pend = 0; m_ovr = 0; m_fc = 8'd0;
        if (pixel_clk) exp_q.push_back(model_exp());
      end else begin
        enter = (m_ph < 0) && vblank && m_pend;
        if (m_ph >= 0 && !vblank) m_ovr = 1;
        if (m_ph == N + 1) begin m_ph = -1; m_fc = m_fc + 8'd1; end
        else if (m_ph >= 0) m_ph++;
        else if (enter)     m_ph = 0;
        m_pend = cpu_commit || (m_pend && !enter);
        exp_q.push_back(model_exp());
      end
    end
  endtask

  task automatic monitor_loop();
    logic [W-1:0] e, a;
    forever begin
      @(negedge pixel_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {busy, cpu_stall, gpu_idle, gpu_we, mem_rd, done, overrun, frame_count,
             mem_addr, e[16], e[16] ? gpu_din : 16'h0};
        check("cycle_outputs", 64'(a), 64'(e));
      end
      if (cap_on && cap_n < N) begin cap[cap_n] = gpu_din; cap_n++; end
      if (gpu_we) begin cap_on = 1; cap_n = 0; end
    end
  endtask

  // driver tasks
  task automatic pulse_commit();
    @(negedge pixel_clk); #1 cpu_commit = 1'b1;
    @(negedge pixel_clk); #1 cpu_commit = 1'b0;
  endtask

  task automatic wait_phase(input int p);
    int n;
    n = 0;
    while (m_ph != p && n < 2000) begin @(negedge pixel_clk); n++; end
    if (m_ph != p) begin
      checks++; errors++;
      $display("FAIL wait_phase t=%0t actual=%0d expected=%0d", $time, m_ph, p);
    end
  endtask

  initial begin
    int stall_cycles;
    for (int i = 0; i < 8192; i++) mem[i] = 16'(i);
    fork
      model_loop();
      monitor_loop();
    join_none
    repeat (3) @(negedge pixel_clk);
    #1 reset = 1'b0;

    // commit then vblank: full copy of word[k] = k
    pulse_commit();
    repeat (3) @(negedge pixel_clk);
    #1 vblank = 1'b1;
    wait_phase(0);
    wait_phase(-1);
    check("frame_count_1", 64'(frame_count), 64'd1);
    check("rect0_left", 64'(cap[1]), 64'd1);
    check("rect63_color", 64'(cap[383]), 64'd383);

    // vblank high without commit: no stall for 1000 cycles
    stall_cycles = 0;
    repeat (1000) begin
      @(negedge pixel_clk);
      if (cpu_stall) stall_cycles++;
    end
    check("no_commit_stall", 64'(stall_cycles), 64'd0);

    // commit during STREAM: back-to-back copy
    for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
    pulse_commit();
    wait_phase(200);
    pulse_commit();
    wait_phase(-1);
    @(negedge pixel_clk);
    check("b2b_grant", 64'(gpu_idle), 64'd1);
    wait_phase(-1);
    check("frame_count_3", 64'(frame_count), 64'd3);

    // vblank drops at G+100: copy completes, overrun sticks
    pulse_commit();
    wait_phase(100);
    #1 vblank = 1'b0;
    wait_phase(N + 1);
    check("late_done", 64'(done), 64'd1);
    wait_phase(-1);
    check("overrun_set", 64'(overrun), 64'd1);
    check("frame_count_4", 64'(frame_count), 64'd4);
    repeat (20) @(negedge pixel_clk);
    check("overrun_sticky", 64'(overrun), 64'd1);

    // async reset at G+50, then a clean copy
    #1 vblank = 1'b1;
    pulse_commit();
    wait_phase(50);
    #2 reset = 1'b1;
    #1 check("async_reset_outputs",
             64'({busy, cpu_stall, gpu_idle, gpu_we, mem_rd, done, overrun,
                  frame_count, mem_addr, dbg_state}), 64'd0);
    repeat (2) @(negedge pixel_clk);
    #1 reset = 1'b0;
    pulse_commit();
    wait_phase(0);
    wait_phase(-1);
    check("post_reset_count", 64'(frame_count), 64'd1);
    check("post_reset_overrun", 64'(overrun), 64'd0);

    // randomized commit / vblank traffic
    for (int it = 0; it < 40; it++) begin
      @(negedge pixel_clk);
      #1 vblank = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) pulse_commit();
      repeat ($urandom_range(1, 60)) @(negedge pixel_clk);
    end
    #1 vblank = 1'b0;
    wait_phase(-1);
    repeat (5) @(negedge pixel_clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
